mem_access_ctrl: RTL and testbench
==================================

// Module: mem_access_ctrl
// PURPOSE
// Upstream sequencer for the data-memory experiment: turns a debounced step button and board
// switches into RAM_B port-A cycles (we/addr/din), and captures read data for the 7-seg display.
// Single-step mode: one write or one read per press. Sweep mode: write all 64 words, read back,
// verify, and report mismatches.
// PARAMETERS
// ADDR_W      6          word-address width (byte address bits [7:2])
// DATA_W      32         data word width
// DEB_CYCLES  1_000_000  stable cycles a button level must hold before it is accepted (10 ms @ 100 MHz)
// RD_LAT      1          RAM read latency in clk cycles, from addr valid to dout valid (1 or 2)
// PORTS
// clk         in   1       system clock; RAM_B clka is driven from the same clock
// rst         in   1       synchronous, active-high reset
// btn_step    in   1       raw push button, asynchronous and bouncing
// sw_write    in   1       1 = step performs a write, 0 = step performs a read
// sw_sweep    in   1       1 = step launches a full sweep, overriding sw_write
// sw_dsel     in   2       pattern select: 00=12345678, 01=87654321, 10=00001111, 11=FFFF1111
// sw_addr     in   ADDR_W  word address used in single-step mode
// mem_rdata   in   DATA_W  RAM_B douta
// mem_we      out  1       RAM_B wea
// mem_addr    out  ADDR_W  RAM_B addra
// mem_wdata   out  DATA_W  RAM_B dina
// disp_data   out  DATA_W  word shown on the display
// busy        out  1       high while the FSM is outside IDLE
// err_cnt     out  7       sweep mismatch count, 0..64, saturating
// BEHAVIOUR
// - Reset values: all outputs 0; FSM = IDLE; debouncer state = released.
// - Synchronizer: btn_step passes through a 2-FF synchronizer, then the debouncer.
// - Debouncer: counter resets whenever the synced level differs from the accepted level. When the
//   count reaches DEB_CYCLES, the accepted level toggles. A 0->1 change of the accepted level gives
//   a 1-cycle step pulse. Presses while busy=1 are dropped, not queued.
// - Input sampling: sw_* are sampled only on the step pulse in IDLE; mid-operation changes are ignored.
// - FSM states: IDLE, WR, RD_ADDR, RD_WAIT, RD_CAP, SW_WR, SW_RD, SW_WAIT, SW_CMP, DONE.
// - IDLE + pulse, sw_sweep=1: addr<=0, err_cnt<=0, go to SW_WR.
// - IDLE + pulse, sw_write=1: go to WR.
// - IDLE + pulse, otherwise: go to RD_ADDR.
// - WR: mem_we=1 for exactly 1 cycle, addr=sw_addr, wdata=pattern.
//   disp_data<=pattern in the same cycle; then go to IDLE.
// - RD_ADDR: mem_we=0, drive addr. RD_WAIT lasts RD_LAT-1 cycles (0 if RD_LAT=1).
//   RD_CAP: disp_data<=mem_rdata; then go to IDLE.
// - SW_WR: one write per cycle, wdata = pattern ^ {{(DATA_W-ADDR_W){1'b0}}, addr}.
//   addr increments after each write; after addr 63 (wrap to 0) go to SW_RD.
// - SW_RD/SW_WAIT/SW_CMP: per address, issue the read and wait RD_LAT cycles.
//   Compare mem_rdata against the expected word; on mismatch err_cnt++ (saturate at 64).
//   After addr 63, go to DONE.
// - DONE: disp_data <= {25'b0, err_cnt}; 1 cycle; then go to IDLE.
// - Total sweep duration: 64 + 64*(RD_LAT+1) + 1 cycles, step pulse to busy falling.
// - mem_we is 0 in every state except WR and SW_WR. addr/wdata hold their last value when idle.
// - rst asserted mid-sweep: next edge returns to IDLE with outputs at reset values, and mem_we is
//   0 that same edge. Already-written RAM contents are not touched.
// - Pulse coinciding with the DONE->IDLE edge: ignored, because busy is still 1 in that cycle.
// STRUCTURE
// - Package mem_exp_pkg: the four pattern constants, an ADDR_W/DATA_W localparam, and the FSM state
//   enum (4-bit encoding).
// - One sub-module, btn_debounce (synchronizer, counter, rising-pulse output), parameterised by
//   DEB_CYCLES.
// - Top level: FSM, address counter, comparator, err_cnt.
// TESTING (bench uses DEB_CYCLES=4, RD_LAT=1, a behavioural 64x32 RAM model)
// - Bounce: btn toggles every 2 cycles for 20 cycles, then held high 10 cycles -> exactly 1 step
//   pulse, 1 operation.
// - Write: sw_write=1, sw_addr=5, sw_dsel=01 -> one cycle with mem_we=1, addr=5, wdata=87654321;
//   disp_data=87654321.
// - Read: after the write, sw_write=0, sw_addr=5 -> disp_data=87654321 RD_LAT+1 cycles after the
//   pulse; mem_we stays 0.
// - Clean sweep: sw_sweep=1, dsel=10 -> RAM[9]=00001118; err_cnt=0; busy high 193 cycles.
// - Faulty sweep: model corrupts the read data at addresses 3 and 40 -> err_cnt=2, disp_data=00000002.
// - Reset mid-sweep: assert rst at sweep cycle 30 -> next edge busy=0, mem_we=0, err_cnt=0,
//   disp_data=0; RAM[0..29] retain the sweep data.

Source files
------------

// File: rtl/mem_exp_pkg.sv
// mem_exp_pkg: shared widths, display patterns and sequencer states for the memory experiment
package mem_exp_pkg;
    localparam int MEM_ADDR_W = 6;
    localparam int MEM_DATA_W = 32;
    localparam logic [MEM_DATA_W-1:0] PAT_0 = 32'h1234_5678;
    localparam logic [MEM_DATA_W-1:0] PAT_1 = 32'h8765_4321;
    localparam logic [MEM_DATA_W-1:0] PAT_2 = 32'h0000_1111;
    localparam logic [MEM_DATA_W-1:0] PAT_3 = 32'hFFFF_1111;
    typedef enum logic [3:0] {
        IDLE, WR, RD_ADDR, RD_WAIT, RD_CAP, SW_WR, SW_RD, SW_WAIT, SW_CMP, DONE
    } state_t;
endpackage

// File: rtl/btn_debounce.sv
// btn_debounce: 2-FF synchronizer, stable-level debouncer and one-cycle press pulse
module btn_debounce #(
    parameter int DEB_CYCLES = 1_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic pulse
);
    localparam int CW = $clog2(DEB_CYCLES + 1);
    logic [1:0] sync;
    logic level;
    logic [CW-1:0] cnt;
    logic hit;
    // the synced level must disagree with the accepted one for DEB_CYCLES straight cycles
    assign hit = (sync[1] != level) && (cnt == CW'(DEB_CYCLES - 1));
    always_ff @(posedge clk) begin
        if (rst) begin
            sync  <= '0;
            level <= 1'b0;
            cnt   <= '0;
            pulse <= 1'b0;
        end else begin
            sync  <= {sync[0], btn};
            cnt   <= (sync[1] == level || hit) ? '0 : cnt + 1'b1;
            level <= level ^ hit;
            pulse <= hit & ~level;
        end
    end
endmodule

// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: step-button sequencer driving single writes/reads or a full write-read-verify sweep
module mem_access_ctrl
    import mem_exp_pkg::*;
#(
    parameter int ADDR_W     = MEM_ADDR_W,
    parameter int DATA_W     = MEM_DATA_W,
    parameter int DEB_CYCLES = 1_000_000,
    parameter int RD_LAT     = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              btn_step,
    input  logic              sw_write,
    input  logic              sw_sweep,
    input  logic [1:0]        sw_dsel,
    input  logic [ADDR_W-1:0] sw_addr,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [DATA_W-1:0] disp_data,
    output logic              busy,
    output logic [6:0]        err_cnt
);
    state_t state, state_nx;
    logic step, last, mism;
    logic [DATA_W-1:0] pat, sel_pat;
    logic [ADDR_W-1:0] addr_nx;

    btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb (
        .clk  (clk),
        .rst  (rst),
        .btn  (btn_step),
        .pulse(step)
    );

    assign sel_pat = sw_dsel == 2'b00 ? PAT_0 : sw_dsel == 2'b01 ? PAT_1 : sw_dsel == 2'b10 ? PAT_2 : PAT_3;
    assign addr_nx = mem_addr + 1'b1;
    assign last    = &mem_addr;
    assign mism    = mem_rdata != (pat ^ {{(DATA_W-ADDR_W){1'b0}}, mem_addr});
    assign mem_we  = state == WR || state == SW_WR;
    assign busy    = state != IDLE;

    always_ff @(posedge clk) state <= rst ? IDLE : state_nx;

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:             state_nx = !step ? IDLE : sw_sweep ? SW_WR : sw_write ? WR : RD_ADDR;
            WR, RD_CAP, DONE: state_nx = IDLE;
            RD_ADDR:          state_nx = RD_LAT > 1 ? RD_WAIT : RD_CAP;
            RD_WAIT:          state_nx = RD_CAP;
            SW_WR:            state_nx = last ? SW_RD : SW_WR;
            SW_RD:            state_nx = RD_LAT > 1 ? SW_WAIT : SW_CMP;
            SW_WAIT:          state_nx = SW_CMP;
            SW_CMP:           state_nx = last ? DONE : SW_RD;
            default:          state_nx = IDLE;
        endcase
    end

    // switches are captured once at the accepted press; everything after runs from the latched copy
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_addr  <= '0;
            mem_wdata <= '0;
            disp_data <= '0;
            err_cnt   <= '0;
            pat       <= '0;
        end else begin
            case (state)
                IDLE: if (step) begin
                    pat       <= sel_pat;
                    mem_wdata <= sel_pat;
                    mem_addr  <= sw_sweep ? '0 : sw_addr;
                    if (sw_sweep) err_cnt <= '0;
                end
                WR:     disp_data <= mem_wdata;
                RD_CAP: disp_data <= mem_rdata;
                SW_WR: begin
                    mem_addr  <= addr_nx;
                    mem_wdata <= pat ^ {{(DATA_W-ADDR_W){1'b0}}, addr_nx};
                end
                SW_CMP: begin
                    mem_addr <= addr_nx;
                    if (mism && err_cnt != 7'd64) err_cnt <= err_cnt + 1'b1;
                end
                DONE:    disp_data <= {{(DATA_W-7){1'b0}}, err_cnt};
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb_mem_access_ctrl: directed table of button operations against a behavioural 64x32 RAM
module tb_mem_access_ctrl;
    logic clk = 1'b0, rst = 1'b1, btn_step = 1'b0, sw_write = 1'b0, sw_sweep = 1'b0;
    logic [1:0] sw_dsel = 2'b00, corrupt = 2'd0;
    logic [5:0] sw_addr = '0;
    logic [31:0] mem_rdata, mem_wdata, disp_data;
    logic mem_we, busy;
    logic [5:0] mem_addr;
    logic [6:0] err_cnt;
    logic [31:0] ram [64];
    logic [31:0] ram_q;
    logic [5:0] rd_addr;
    int pass_cnt = 0, total = 0;
    int we_tot = 0, busy_tot = 0, rises_tot = 0;
    logic busy_q = 1'b0;
    logic [5:0] we_addr = '0;
    logic [31:0] we_data = '0;
    int d_we, d_busy, d_rises;

    typedef struct {
        logic sweep, write, bounce;
        logic [1:0] dsel, corrupt;
        logic [5:0] addr;
        logic [31:0] disp;
        logic [6:0] err;
        int we, busy;
    } vec_t;
    vec_t v[12];

    mem_access_ctrl #(.DEB_CYCLES(4), .RD_LAT(1)) u_dut (
        .clk(clk), .rst(rst), .btn_step(btn_step), .sw_write(sw_write), .sw_sweep(sw_sweep),
        .sw_dsel(sw_dsel), .sw_addr(sw_addr), .mem_rdata(mem_rdata), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .disp_data(disp_data), .busy(busy),
        .err_cnt(err_cnt)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_we) ram[mem_addr] <= mem_wdata;
        ram_q   <= ram[mem_addr];
        rd_addr <= mem_addr;
    end
    assign mem_rdata = ram_q ^ {31'b0, corrupt == 2'd2 || (corrupt == 2'd1 && (rd_addr == 6'd3 || rd_addr == 6'd40))};

    always @(negedge clk) begin
        if (mem_we) begin
            we_tot  <= we_tot + 1;
            we_addr <= mem_addr;
            we_data <= mem_wdata;
        end
        if (busy) busy_tot <= busy_tot + 1;
        if (busy && !busy_q) rises_tot <= rises_tot + 1;
        busy_q <= busy;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    function automatic logic [31:0] pat(input logic [1:0] d);
        return d == 2'd0 ? 32'h12345678 : d == 2'd1 ? 32'h87654321 : d == 2'd2 ? 32'h00001111 : 32'hFFFF1111;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic run_op(input logic bounce);
        int b_we, b_busy, b_rises, n;
        b_we = we_tot; b_busy = busy_tot; b_rises = rises_tot;
        if (bounce) for (int i = 0; i < 10; i++) begin
            btn_step = ~btn_step;
            repeat (2) @(negedge clk);
        end
        btn_step = 1'b1;
        repeat (10) @(negedge clk);
        n = 0;
        while ((rises_tot == b_rises || busy) && n < 400) begin
            @(negedge clk);
            n++;
        end
        btn_step = 1'b0;
        repeat (12) @(negedge clk);
        check("op_finished", 32'(n < 400), 32'd1);
        d_we = we_tot - b_we; d_busy = busy_tot - b_busy; d_rises = rises_tot - b_rises;
    endtask

    initial begin
        int n, bad, b_we, b_busy, b_rises;
        //      sweep write bounce dsel   corrupt addr   disp          err    we busy
        v[0]  = '{1'b0, 1'b1, 1'b1, 2'b01, 2'd0, 6'd5,  32'h87654321, 7'd0,  1,  1};
        v[1]  = '{1'b0, 1'b0, 1'b0, 2'b00, 2'd0, 6'd5,  32'h87654321, 7'd0,  0,  2};
        v[2]  = '{1'b1, 1'b0, 1'b0, 2'b10, 2'd0, 6'd0,  32'h00000000, 7'd0,  64, 193};
        v[3]  = '{1'b0, 1'b0, 1'b0, 2'b00, 2'd0, 6'd9,  32'h00001118, 7'd0,  0,  2};
        v[4]  = '{1'b1, 1'b0, 1'b0, 2'b10, 2'd1, 6'd0,  32'h00000002, 7'd2,  64, 193};
        v[5]  = '{1'b0, 1'b1, 1'b0, 2'b11, 2'd0, 6'd63, 32'hFFFF1111, 7'd2,  1,  1};
        v[6]  = '{1'b0, 1'b0, 1'b0, 2'b00, 2'd0, 6'd63, 32'hFFFF1111, 7'd2,  0,  2};
        v[7]  = '{1'b0, 1'b0, 1'b0, 2'b01, 2'd0, 6'd40, 32'h00001139, 7'd2,  0,  2};
        v[8]  = '{1'b1, 1'b0, 1'b0, 2'b00, 2'd2, 6'd0,  32'h00000040, 7'd64, 64, 193};
        v[9]  = '{1'b0, 1'b1, 1'b0, 2'b00, 2'd0, 6'd0,  32'h12345678, 7'd64, 1,  1};
        v[10] = '{1'b1, 1'b1, 1'b0, 2'b01, 2'd0, 6'd17, 32'h00000000, 7'd0,  64, 193};
        v[11] = '{1'b0, 1'b0, 1'b0, 2'b10, 2'd0, 6'd1,  32'h87654320, 7'd0,  0,  2};

        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_we", 32'(mem_we), 32'd0);
        check("rst_err", 32'(err_cnt), 32'd0);
        check("rst_disp", disp_data, 32'd0);
        check("rst_addr", 32'(mem_addr), 32'd0);
        check("rst_wdata", mem_wdata, 32'd0);
        repeat (5) @(negedge clk);

        for (int i = 0; i < 12; i++) begin
            sw_sweep = v[i].sweep; sw_write = v[i].write; sw_dsel = v[i].dsel;
            sw_addr = v[i].addr; corrupt = v[i].corrupt;
            run_op(v[i].bounce);
            corrupt = 2'd0;
            check($sformatf("v%0d_disp", i), disp_data, v[i].disp);
            check($sformatf("v%0d_err", i), 32'(err_cnt), 32'(v[i].err));
            check($sformatf("v%0d_we_cycles", i), 32'(d_we), 32'(v[i].we));
            check($sformatf("v%0d_busy_cycles", i), 32'(d_busy), 32'(v[i].busy));
            check($sformatf("v%0d_ops", i), 32'(d_rises), 32'd1);
            if (v[i].write && !v[i].sweep) begin
                check($sformatf("v%0d_we_addr", i), 32'(we_addr), 32'(v[i].addr));
                check($sformatf("v%0d_we_data", i), we_data, pat(v[i].dsel));
            end
        end

        // reset during the write phase of a sweep, at busy cycle 30 (addr 29 on the bus)
        sw_sweep = 1'b1; sw_write = 1'b0; sw_dsel = 2'b11;
        btn_step = 1'b1;
        n = 0;
        while (!busy && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("rst_sweep_started", 32'(busy), 32'd1);
        btn_step = 1'b0;
        repeat (29) @(negedge clk);
        check("rst_sweep_addr", 32'(mem_addr), 32'd29);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_we", 32'(mem_we), 32'd0);
        check("midrst_err", 32'(err_cnt), 32'd0);
        check("midrst_disp", disp_data, 32'd0);
        check("midrst_addr", 32'(mem_addr), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        bad = 0;
        for (int i = 0; i < 30; i++) if (ram[i] !== (32'hFFFF1111 ^ 32'(i))) bad++;
        check("midrst_ram_kept", 32'(bad), 32'd0);
        check("midrst_ram30", ram[30], 32'h8765433F);
        repeat (15) @(negedge clk);

        // second press and switch changes during a sweep must have no effect
        sw_sweep = 1'b1; sw_write = 1'b0; sw_dsel = 2'b00;
        b_we = we_tot; b_busy = busy_tot; b_rises = rises_tot;
        btn_step = 1'b1;
        n = 0;
        while (!busy && n < 100) begin
            @(negedge clk);
            n++;
        end
        btn_step = 1'b0;
        sw_sweep = 1'b0; sw_write = 1'b1; sw_dsel = 2'b11;
        repeat (15) @(negedge clk);
        btn_step = 1'b1;
        repeat (10) @(negedge clk);
        btn_step = 1'b0;
        n = 0;
        while (busy && n < 400) begin
            @(negedge clk);
            n++;
        end
        check("drop_finished", 32'(n < 400), 32'd1);
        repeat (20) @(negedge clk);
        check("drop_ops", 32'(rises_tot - b_rises), 32'd1);
        check("drop_we_cycles", 32'(we_tot - b_we), 32'd64);
        check("drop_busy_cycles", 32'(busy_tot - b_busy), 32'd193);
        check("drop_err", 32'(err_cnt), 32'd0);
        check("drop_ram5", ram[5], 32'h12345678 ^ 32'd5);

        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end
endmodule
